dmem_responder: RTL and testbench

Data-memory responder for the pipelined RV32I core's load/store port. Accepts one request at a time over a valid/ready handshake and serves it from an internal word array after a configurable wait-state count. Supports byte, halfword and word access, with sign or zero extension on loads. Returns the result over a response handshake with an error flag. It is the responder end of the core's MEM-stage data interface and replaces the zero-latency combinational data memory for multi-cycle memory timing.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and the request legality check for the data-memory responder.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Unsigned-extend sizes only exist for loads, so a store with BU/HU is illegal.
    function automatic logic access_err(input logic we, input logic [2:0] size,
                                        input logic [1:0] lsb, input logic in_range);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lsb[0];
            SZ_W:    bad = (lsb != 2'b00);
            SZ_BU:   bad = we;
            SZ_HU:   bad = we | lsb[0];
            default: bad = 1'b1;
        endcase
        return bad | ~in_range;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load extraction with extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lsb,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword[{addr_lsb, 3'b000} +: 8];
    assign rhalf = rword[{addr_lsb[1], 4'b0000} +: 16];

    // size[2] marks the unsigned variants, which suppress sign extension.
    always_comb begin
        be    = 4'b0000;
        wword = wdata;
        rdata = 32'd0;
        case (size[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lsb;
                wword = {4{wdata[7:0]}};
                rdata = {{24{rbyte[7] & ~size[2]}}, rbyte};
            end
            2'b01: begin
                be    = addr_lsb[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
                rdata = {{16{rhalf[15] & ~size[2]}}, rhalf};
            end
            2'b10: begin
                be    = 4'b1111;
                rdata = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, WAIT_CYCLES wait states, registered read word.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rword_q;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic [31:0]       ld_data;

    assign req_ready = (state == S_IDLE) & ~rst;
    assign in_range  = 32'(req_addr[ADDR_W-1:2]) < 32'(DEPTH_WORDS);
    assign idx       = addr_q[2 +: IDX_W];

    dmem_lane_align u_align (
        .addr_lsb (addr_q[1:0]),
        .size     (size_q),
        .wdata    (wdata_q),
        .rword    (rword_q),
        .be       (be),
        .wword    (wword),
        .rdata    (ld_data)
    );

    // The read word is registered in EXEC and aligned on the way into rsp_rdata,
    // so the response appears one edge after the array access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= 3'd0;
            wdata_q   <= 32'd0;
            err_q     <= 1'b0;
            rword_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        wdata_q <= req_wdata;
                        err_q   <= access_err(req_we, req_size, req_addr[1:0], in_range);
                        if (WAIT_CYCLES > 0) begin
                            cnt   <= 4'(WAIT_CYCLES - 1);
                            state <= S_WAIT;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_EXEC;
                    else             cnt   <= cnt - 4'd1;
                end
                S_EXEC: begin
                    rword_q <= err_q ? 32'd0 : mem[idx];
                    state   <= S_RESP;
                end
                S_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (err_q | we_q) ? 32'd0 : ld_data;
                        rsp_err   <= err_q;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
        end else if (state == S_EXEC && we_q && !err_q) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

    logic        clk;
    logic        rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [9:0]  req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata, rsp_rdata;

    logic        rst_b, req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
    logic [9:0]  req_addr_b;
    logic [2:0]  req_size_b;
    logic [31:0] req_wdata_b, rsp_rdata_b;

    int tests = 0;
    int fails = 0;
    logic [7:0] mem_m [0:255];

    dmem_responder #(.ADDR_W(10), .DEPTH_WORDS(64), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(10), .DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_size(req_size_b), .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b),
        .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic model_err(input logic we, input int a, input logic [2:0] sz);
        if (sz == 3 || sz == 6 || sz == 7) return 1'b1;
        if (we && (sz == 4 || sz == 5)) return 1'b1;
        if ((sz == 1 || sz == 5) && (a % 2 != 0)) return 1'b1;
        if (sz == 2 && (a % 4 != 0)) return 1'b1;
        if (a / 4 >= 64) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input int a, input logic [2:0] sz);
        int v;
        case (sz)
            0, 4: begin
                v = mem_m[a];
                if (sz == 0 && v >= 128) v -= 256;
            end
            1, 5: begin
                v = mem_m[a] + 256 * mem_m[a+1];
                if (sz == 1 && v >= 32768) v -= 65536;
            end
            default: v = mem_m[a] + (mem_m[a+1] << 8) + (mem_m[a+2] << 16) + (mem_m[a+3] << 24);
        endcase
        return 32'(v);
    endfunction

    task automatic model_store(input int a, input logic [2:0] sz, input logic [31:0] wd);
        int n;
        n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        for (int i = 0; i < n; i++) mem_m[a+i] = wd[8*i +: 8];
    endtask

    // One full transaction on the WAIT_CYCLES=1 instance, checked against the model.
    task automatic txn(input logic we, input logic [9:0] a, input logic [2:0] sz, input logic [31:0] wd,
                       input int hold, output logic [31:0] rd, output logic e);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          k, g;
        exp_err = model_err(we, int'(a), sz);
        exp_rd  = (exp_err || we) ? 32'd0 : model_load(int'(a), sz);
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 20) begin @(negedge clk); g++; end
        req_valid = 1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0; req_we = $urandom; req_addr = 10'($urandom); req_size = 3'($urandom); req_wdata = $urandom;
        k = 0;
        while (!rsp_valid && k < 40) begin @(posedge clk); #1; k++; end
        tests++;
        if (k !== 3) begin fails++; $display("FAIL latency a=%h: got %0d edges, expected 3", a, k); end
        rd = rsp_rdata; e = rsp_err;
        tests++;
        if (rsp_rdata !== exp_rd) begin fails++; $display("FAIL rdata we=%b a=%h sz=%0d: got %h expected %h", we, a, sz, rsp_rdata, exp_rd); end
        tests++;
        if (rsp_err !== exp_err) begin fails++; $display("FAIL err we=%b a=%h sz=%0d: got %b expected %b", we, a, sz, rsp_err, exp_err); end
        repeat (hold) begin
            @(posedge clk); #1;
            tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== e || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold: got valid=%b rdata=%h err=%b ready=%b expected 1/%h/%b/0", rsp_valid, rsp_rdata, rsp_err, req_ready, rd, e);
            end
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL handshake: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
        end
        if (!exp_err && we) model_store(int'(a), sz, wd);
    endtask

    task automatic test_reset;
        rst = 1; rst_b = 1;
        #2;
        tests++;
        if (req_ready !== 0 || rsp_valid !== 0 || rsp_rdata !== 0 || rsp_err !== 0) begin
            fails++;
            $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b expected 0/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (2) @(negedge clk);
        rst = 0; rst_b = 0;
        #1;
        tests++;
        if (req_ready !== 1 || req_ready_b !== 1) begin
            fails++;
            $display("FAIL reset_ready: got %b/%b expected 1/1", req_ready, req_ready_b);
        end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic e;
        txn(1, 10'h010, 3'b010, 32'h12345678, 0, rd, e);
        txn(0, 10'h010, 3'b010, 32'h0, 0, rd, e);
        tests++;
        if (rd !== 32'h12345678 || e !== 0) begin fails++; $display("FAIL lw_after_sw: got %h/%b expected 12345678/0", rd, e); end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic e;
        txn(1, 10'h011, 3'b000, {24'($urandom), 8'hAB}, 0, rd, e);
        txn(0, 10'h010, 3'b010, 32'h0, 0, rd, e);
        tests++;
        if (rd !== 32'h1234AB78) begin fails++; $display("FAIL sb_word: got %h expected 1234ab78", rd); end
        txn(0, 10'h011, 3'b000, 32'h0, 0, rd, e);
        tests++;
        if (rd !== 32'hFFFFFFAB) begin fails++; $display("FAIL lb: got %h expected ffffffab", rd); end
        txn(0, 10'h011, 3'b100, 32'h0, 0, rd, e);
        tests++;
        if (rd !== 32'h000000AB) begin fails++; $display("FAIL lbu: got %h expected 000000ab", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic e;
        txn(1, 10'h022, 3'b001, {16'($urandom), 16'h8001}, 0, rd, e);
        txn(0, 10'h022, 3'b001, 32'h0, 0, rd, e);
        tests++;
        if (rd !== 32'hFFFF8001) begin fails++; $display("FAIL lh: got %h expected ffff8001", rd); end
        txn(0, 10'h022, 3'b101, 32'h0, 0, rd, e);
        tests++;
        if (rd !== 32'h00008001) begin fails++; $display("FAIL lhu: got %h expected 00008001", rd); end
        txn(0, 10'h020, 3'b010, 32'h0, 0, rd, e);
        tests++;
        if (rd !== 32'h80010000) begin fails++; $display("FAIL sh_word: got %h expected 80010000", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic e;
        logic        we_t [6]  = '{0, 1, 0, 0, 1, 1};
        logic [9:0]  a_t  [6]  = '{10'h013, 10'h005, 10'h000, 10'h100, 10'h012, 10'h010};
        logic [2:0]  sz_t [6]  = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b010, 3'b100};
        for (int i = 0; i < 6; i++) begin
            txn(we_t[i], a_t[i], sz_t[i], 32'hFFFFFFFF, 0, rd, e);
            tests++;
            if (e !== 1 || rd !== 0) begin fails++; $display("FAIL err_case%0d: got err=%b rdata=%h expected 1/0", i, e, rd); end
        end
        txn(0, 10'h010, 3'b010, 32'h0, 0, rd, e);
        tests++;
        if (rd !== 32'h1234AB78) begin fails++; $display("FAIL err_no_write: got %h expected 1234ab78", rd); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic e;
        txn(0, 10'h020, 3'b010, 32'h0, 5, rd, e);
        txn(1, 10'h02C, 3'b010, 32'hCAFEF00D, 3, rd, e);
    endtask

    task automatic test_random;
        logic [31:0] rd; logic e;
        logic [9:0]  a;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 63));
            txn(1'($urandom), a, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2), rd, e);
        end
    endtask

    task automatic test_mid_reset;
        int k;
        logic seen;
        @(negedge clk);
        req_valid_b = 1; req_we_b = 1; req_addr_b = 10'h000; req_size_b = 3'b010; req_wdata_b = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid_b = 0;
        @(posedge clk); #1;
        rst_b = 1;
        #1;
        tests++;
        if (rsp_valid_b !== 0 || req_ready_b !== 0) begin
            fails++;
            $display("FAIL midrst_state: got valid=%b ready=%b expected 0/0", rsp_valid_b, req_ready_b);
        end
        @(negedge clk);
        rst_b = 0;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (rsp_valid_b) seen = 1; end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL midrst_no_rsp: got rsp_valid=1 expected 0"); end
        @(negedge clk);
        req_valid_b = 1; req_we_b = 0; req_addr_b = 10'h000; req_size_b = 3'b010;
        @(posedge clk); #1;
        req_valid_b = 0;
        k = 0;
        while (!rsp_valid_b && k < 40) begin @(posedge clk); #1; k++; end
        tests++;
        if (k !== 5) begin fails++; $display("FAIL w3_latency: got %0d edges expected 5", k); end
        tests++;
        if (rsp_rdata_b !== 32'h0 || rsp_err_b !== 0) begin
            fails++;
            $display("FAIL midrst_lw: got %h/%b expected 00000000/0", rsp_rdata_b, rsp_err_b);
        end
        rsp_ready_b = 1;
        @(posedge clk); #1;
        rsp_ready_b = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        req_valid = 0; req_we = 0; req_addr = 0; req_size = 0; req_wdata = 0; rsp_ready = 0;
        req_valid_b = 0; req_we_b = 0; req_addr_b = 0; req_size_b = 0; req_wdata_b = 0; rsp_ready_b = 0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
